// File: rtl/flash_seq_arb.sv
// Two-port arbiter and command sequencer for a byte-mode parallel NOR flash.
// Owns all strobe timing plus READ / PROGRAM / BLOCK ERASE command sequences with status polling.
module flash_seq_arb #(
  parameter int AW      = 24,
  parameter int TACC    = 6,
  parameter int TWP     = 4,
  parameter int TWH     = 2,
  parameter int STS_DLY = 4,
  parameter int TO_CYC  = 250000000
) (
  input  logic          clk_f,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    op0,
  input  logic [1:0]    op1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [7:0]    wdata0,
  input  logic [7:0]    wdata1,
  output logic [1:0]    done,
  output logic [7:0]    rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] NF_A,
  output logic [7:0]    NF_D_O,
  output logic          NF_D_OE,
  input  logic [7:0]    NF_D_I,
  output logic          NF_CE,
  output logic          NF_OE,
  output logic          NF_WE,
  input  logic          NF_STS
);

  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] RD_CAP   = CW'(TACC);
  localparam logic [CW-1:0] RD_LAST  = CW'(TACC + 1);
  localparam logic [CW-1:0] WE_LAST  = CW'(TWP - 1);
  localparam logic [CW-1:0] WH_LAST  = CW'(TWH - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(STS_DLY - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TO_CYC);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CYC, S_WR_SETUP, S_WR_LOW, S_WR_HOLD,
    S_STS_DLY, S_STS_WAIT, S_STAT_RD, S_CLEAN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      step_q, step_d;
  logic            cln_q, cln_d;
  logic            gnt_q, gnt_d;
  logic            rr_q, rr_d;
  logic            serr_q, serr_d;
  logic            tout_q, tout_d;
  logic [AW-1:0]   addr_q;
  logic [7:0]      rdata_q;
  logic [1:0]      op_q;
  logic [7:0]      wdata_q;

  logic            gnt_fire, gnt_idx, rd_low;
  logic [1:0]      sel_op;
  logic [7:0]      cmd;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  function automatic logic sr_bad(input logic [7:0] sr);
    return !sr[7] | sr[5] | sr[4] | sr[3] | sr[1];
  endfunction

  assign gnt_fire = (state_q == S_IDLE) && NF_STS && (req != 2'b00);
  assign gnt_idx  = (req == 2'b11) ? ~rr_q : req[1];
  assign sel_op   = gnt_idx ? op1 : op0;

  // Clean-up writes reuse the write path; step 1 is always the 0xFF read-array command.
  always_comb begin
    cmd = 8'hFF;
    if (cln_q)               cmd = (step_q == 2'd0) ? 8'h50 : 8'hFF;
    else if (op_q == 2'b01)  cmd = (step_q == 2'd0) ? 8'h40 : wdata_q;
    else                     cmd = (step_q == 2'd0) ? 8'h20 : 8'hD0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    cln_d   = cln_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    serr_d  = serr_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_fire) begin
          gnt_d   = gnt_idx;
          if (req == 2'b11) rr_d = gnt_idx;
          cnt_d   = '0;
          step_d  = 2'd0;
          cln_d   = 1'b0;
          serr_d  = 1'b0;
          tout_d  = 1'b0;
          state_d = (sel_op[0] == sel_op[1]) ? S_RD_CYC : S_WR_SETUP;
        end
      end
      S_RD_CYC, S_STAT_RD: begin
        if (state_q == S_STAT_RD && cnt_q == RD_CAP) serr_d = sr_bad(NF_D_I);
        if (cnt_q == RD_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == S_RD_CYC) ? S_DONE : S_CLEAN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_LOW;
      end
      S_WR_LOW: begin
        if (cnt_q == WE_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_WR_HOLD: begin
        if (cnt_q == WH_LAST) begin
          cnt_d = '0;
          if (step_q == 2'd0) begin
            step_d  = 2'd1;
            state_d = S_WR_SETUP;
          end else begin
            state_d = cln_q ? S_DONE : S_STS_DLY;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_STS_DLY: begin
        if (cnt_q == DLY_LAST) begin
          cnt_d   = '0;
          state_d = S_STS_WAIT;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_STS_WAIT: begin
        if (NF_STS) begin
          cnt_d   = '0;
          state_d = S_STAT_RD;
        end else if (cnt_q == TO_LIM) begin
          tout_d  = 1'b1;
          state_d = S_CLEAN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_CLEAN: begin
        cln_d   = 1'b1;
        cnt_d   = '0;
        step_d  = (serr_q | tout_q) ? 2'd0 : 2'd1;
        state_d = S_WR_SETUP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_f) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 2'd0;
      cln_q   <= 1'b0;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b1;
      serr_q  <= 1'b0;
      tout_q  <= 1'b0;
      addr_q  <= '0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      cln_q   <= cln_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      serr_q  <= serr_d;
      tout_q  <= tout_d;
      if (gnt_fire) addr_q <= gnt_idx ? addr1 : addr0;
      if (state_q == S_RD_CYC && cnt_q == RD_CAP) rdata_q <= NF_D_I;
    end
  end

  always_ff @(posedge clk_f) begin
    if (gnt_fire) begin
      op_q    <= sel_op;
      wdata_q <= gnt_idx ? wdata1 : wdata0;
    end
  end

  // Read bus cycle: one address-setup cycle, TACC strobe-low cycles, one recovery cycle.
  assign rd_low  = (state_q == S_RD_CYC || state_q == S_STAT_RD) && (cnt_q != '0) && (cnt_q <= RD_CAP);
  assign NF_OE   = !rd_low;
  assign NF_CE   = !(rd_low || state_q == S_WR_SETUP || state_q == S_WR_LOW);
  assign NF_WE   = !(state_q == S_WR_LOW);
  assign NF_D_OE = (state_q == S_WR_SETUP) || (state_q == S_WR_LOW) || (state_q == S_WR_HOLD);
  assign NF_D_O  = cmd;
  assign NF_A    = addr_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign err     = (state_q == S_DONE) && (serr_q | tout_q);
  assign rdata   = rdata_q;

endmodule
